// File: rtl/mem_wb.sv
// mem_wb -- MEM/WB pipeline register.
//
// Captures the MEM-stage result on every rising edge, selects and extends
// load data (little-endian byte/halfword lanes), and drives the register
// file write port, the HI/LO write port and a commit trace from registered
// state. A retired-instruction counter is kept for debug.
//
// Ports:
//   clk, rst              clock; asynchronous active-low reset
//   stall_mem, stall_wb   pipeline controller stalls
//   flush                 kill the in-flight MEM instruction
//   mem_valid, mem_pc     MEM instruction valid / PC
//   mem_we, mem_waddr     GPR write request
//   mem_alu               non-load result
//   mem_op                load type (000 none, 001 LB, 010 LBU, 011 LH,
//                         100 LHU, 101 LW; 110/111 behave as none)
//   mem_addr_lo           low two bits of the load address
//   mem_rdata             raw data-memory word
//   mem_hilo_we, mem_hi, mem_lo   HI/LO write request
//   wb_we, wb_waddr, wb_wdata     register file write port
//   wb_hilo_we, wb_hi, wb_lo      HI/LO write port
//   wb_valid, wb_pc               commit trace
//   retire_cnt                    retired-instruction count (wraps)
module mem_wb #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_mem,
  input  logic          stall_wb,
  input  logic          flush,
  input  logic          mem_valid,
  input  logic [DW-1:0] mem_pc,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_waddr,
  input  logic [DW-1:0] mem_alu,
  input  logic [2:0]    mem_op,
  input  logic [1:0]    mem_addr_lo,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_hilo_we,
  input  logic [DW-1:0] mem_hi,
  input  logic [DW-1:0] mem_lo,
  output logic          wb_we,
  output logic [AW-1:0] wb_waddr,
  output logic [DW-1:0] wb_wdata,
  output logic          wb_hilo_we,
  output logic [DW-1:0] wb_hi,
  output logic [DW-1:0] wb_lo,
  output logic          wb_valid,
  output logic [DW-1:0] wb_pc,
  output logic [31:0]   retire_cnt
);

  typedef enum logic [2:0] {
    OP_NONE = 3'b000,
    OP_LB   = 3'b001,
    OP_LBU  = 3'b010,
    OP_LH   = 3'b011,
    OP_LHU  = 3'b100,
    OP_LW   = 3'b101
  } load_op_e;

  logic [7:0]    load_byte;
  logic [15:0]   load_half;
  logic [DW-1:0] wdata_next;
  logic          load_bubble;
  logic          hold;

  // Lane selection: byte lane k is mem_rdata[8k+7:8k]; the halfword is
  // picked by addr_lo[1] only (misalignment is trapped upstream).
  assign load_byte = mem_rdata[{mem_addr_lo, 3'b000} +: 8];
  assign load_half = mem_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    // NOTE: default assignment first so every path drives wdata_next and
    // no latch is inferred; unused encodings fall back to the ALU result.
    wdata_next = mem_alu;
    case (load_op_e'(mem_op))
      OP_LB:   wdata_next = {{(DW-8){load_byte[7]}}, load_byte};
      OP_LBU:  wdata_next = {{(DW-8){1'b0}}, load_byte};
      OP_LH:   wdata_next = {{(DW-16){load_half[15]}}, load_half};
      OP_LHU:  wdata_next = {{(DW-16){1'b0}}, load_half};
      OP_LW:   wdata_next = mem_rdata;
      default: wdata_next = mem_alu;
    endcase
  end

  // Flush outranks every stall combination; a stalled MEM feeding a running
  // WB must not re-commit the same instruction, hence the bubble.
  assign load_bubble = flush | (stall_mem & ~stall_wb);
  assign hold        = ~flush & stall_mem & stall_wb;

  // NOTE: all pipeline state is updated with non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_we      <= 1'b0;
      wb_waddr   <= '0;
      wb_wdata   <= '0;
      wb_hilo_we <= 1'b0;
      wb_hi      <= '0;
      wb_lo      <= '0;
      wb_valid   <= 1'b0;
      wb_pc      <= '0;
      retire_cnt <= '0;
    end else if (load_bubble) begin
      // Bubble clears the write ports and trace; the counter is kept.
      wb_we      <= 1'b0;
      wb_waddr   <= '0;
      wb_wdata   <= '0;
      wb_hilo_we <= 1'b0;
      wb_hi      <= '0;
      wb_lo      <= '0;
      wb_valid   <= 1'b0;
      wb_pc      <= '0;
    end else if (!hold) begin
      // The $zero qualification keeps the write port quiet for r0 even
      // though the register file ignores such writes anyway.
      wb_we      <= mem_valid & mem_we & (mem_waddr != '0);
      wb_waddr   <= mem_waddr;
      wb_wdata   <= wdata_next;
      wb_hilo_we <= mem_valid & mem_hilo_we;
      wb_hi      <= mem_hi;
      wb_lo      <= mem_lo;
      wb_valid   <= mem_valid;
      wb_pc      <= mem_pc;
      if (mem_valid) retire_cnt <= retire_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_mem_wb.sv
// Scoreboard bench for mem_wb: each driven cycle pushes the expected
// post-edge output set; a monitor pops and compares after every edge.
module tb_mem_wb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_mem = 1'b0, stall_wb = 1'b0, flush = 1'b0;
  logic        mem_valid = 1'b0, mem_we = 1'b0, mem_hilo_we = 1'b0;
  logic [31:0] mem_pc = '0, mem_alu = '0, mem_rdata = '0, mem_hi = '0, mem_lo = '0;
  logic [4:0]  mem_waddr = '0;
  logic [2:0]  mem_op = '0;
  logic [1:0]  mem_addr_lo = '0;
  logic        wb_we, wb_hilo_we, wb_valid;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata, wb_hi, wb_lo, wb_pc, retire_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        hilo_we;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] cnt;
  } wb_t;

  wb_t exp_q[$];
  wb_t model = '{default: '0};

  mem_wb #(.DW(32), .AW(5)) dut (
    .clk(clk), .rst(rst),
    .stall_mem(stall_mem), .stall_wb(stall_wb), .flush(flush),
    .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_alu(mem_alu), .mem_op(mem_op),
    .mem_addr_lo(mem_addr_lo), .mem_rdata(mem_rdata),
    .mem_hilo_we(mem_hilo_we), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .wb_hilo_we(wb_hilo_we), .wb_hi(wb_hi), .wb_lo(wb_lo),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_all(input string tag, input wb_t e);
    check({tag, ".we"},      32'(wb_we),      32'(e.we));
    check({tag, ".waddr"},   32'(wb_waddr),   32'(e.waddr));
    check({tag, ".wdata"},   wb_wdata,        e.wdata);
    check({tag, ".hilo_we"}, 32'(wb_hilo_we), 32'(e.hilo_we));
    check({tag, ".hi"},      wb_hi,           e.hi);
    check({tag, ".lo"},      wb_lo,           e.lo);
    check({tag, ".valid"},   32'(wb_valid),   32'(e.valid));
    check({tag, ".pc"},      wb_pc,           e.pc);
    check({tag, ".cnt"},     retire_cnt,      e.cnt);
  endtask

  // Drive one cycle of stimulus and push the expected post-edge state.
  // exp_wdata is the hand-computed write data for a capture.
  task automatic drive(input logic fl, input logic sm, input logic sw,
                       input logic v, input logic we, input logic [4:0] wa,
                       input logic [2:0] op, input logic [1:0] alo,
                       input logic [31:0] alu, input logic [31:0] rdata,
                       input logic hwe, input logic [31:0] hi, input logic [31:0] lo,
                       input logic [31:0] pc, input logic [31:0] exp_wdata);
    @(negedge clk);
    flush = fl; stall_mem = sm; stall_wb = sw;
    mem_valid = v; mem_we = we; mem_waddr = wa; mem_op = op; mem_addr_lo = alo;
    mem_alu = alu; mem_rdata = rdata; mem_hilo_we = hwe; mem_hi = hi; mem_lo = lo;
    mem_pc = pc;
    if (fl || (sm && !sw)) begin
      model = '{default: '0, cnt: model.cnt};
    end else if (!(sm && sw)) begin
      model.we      = v & we & (wa != 5'd0);
      model.waddr   = wa;
      model.wdata   = exp_wdata;
      model.hilo_we = v & hwe;
      model.hi      = hi;
      model.lo      = lo;
      model.valid   = v;
      model.pc      = pc;
      if (v) model.cnt = model.cnt + 32'd1;
    end
    exp_q.push_back(model);
  endtask

  // Convenience: capture a valid load/ALU op writing reg wa.
  task automatic cap(input logic [4:0] wa, input logic [2:0] op, input logic [1:0] alo,
                     input logic [31:0] alu, input logic [31:0] rdata,
                     input logic [31:0] pc, input logic [31:0] exp_wdata);
    drive(0, 0, 0, 1, 1, wa, op, alo, alu, rdata, 0, 32'h0, 32'h0, pc, exp_wdata);
  endtask

  // Monitor: pops one expectation per edge once stimulus has queued one.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) check_all("sb", exp_q.pop_front());
    end
  end

  localparam logic [31:0] RD = 32'h80FF7F01;

  initial begin
    // Reset state while rst is low from time 0.
    #2;
    check_all("reset0", '{default: '0});
    @(negedge clk);
    rst = 1'b1;

    // ALU write to r5, then the same to $zero.
    cap(5'd5, 3'b000, 2'd0, 32'h12345678, 32'h0, 32'h100, 32'h12345678);
    cap(5'd0, 3'b000, 2'd0, 32'h12345678, 32'h0, 32'h104, 32'h12345678);

    // Load extension with rdata 0x80FF7F01.
    cap(5'd1, 3'b001, 2'd2, 32'h0, RD, 32'h108, 32'hFFFFFFFF); // LB lane 2
    cap(5'd2, 3'b010, 2'd3, 32'h0, RD, 32'h10C, 32'h00000080); // LBU lane 3
    cap(5'd3, 3'b001, 2'd0, 32'h0, RD, 32'h110, 32'h00000001); // LB lane 0
    cap(5'd4, 3'b011, 2'd2, 32'h0, RD, 32'h114, 32'hFFFF80FF); // LH upper
    cap(5'd6, 3'b100, 2'd0, 32'h0, RD, 32'h118, 32'h00007F01); // LHU lower
    cap(5'd8, 3'b011, 2'd3, 32'h0, RD, 32'h11C, 32'hFFFF80FF); // LH, bit0 ignored
    cap(5'd9, 3'b101, 2'd1, 32'h0, RD, 32'h120, 32'h80FF7F01); // LW
    cap(5'd10, 3'b110, 2'd0, 32'hCAFEF00D, RD, 32'h124, 32'hCAFEF00D); // 110 = none

    // Hold for 3 cycles with different inputs present, then bubble.
    cap(5'd11, 3'b000, 2'd0, 32'h0BADBEEF, 32'h0, 32'h128, 32'h0BADBEEF);
    for (int i = 0; i < 3; i++)
      drive(0, 1, 1, 1, 1, 5'd12, 3'b000, 2'd0, 32'h11111111, 32'h0, 1, 32'h1, 32'h2, 32'h200, 32'h0);
    drive(0, 1, 0, 1, 1, 5'd12, 3'b000, 2'd0, 32'h11111111, 32'h0, 1, 32'h1, 32'h2, 32'h200, 32'h0);

    // Flush with valid write to r7 and both stalls high -> bubble.
    cap(5'd13, 3'b000, 2'd0, 32'h13131313, 32'h0, 32'h12C, 32'h13131313);
    drive(1, 1, 1, 1, 1, 5'd7, 3'b000, 2'd0, 32'h77777777, 32'h0, 1, 32'h7, 32'h7, 32'h130, 32'h0);

    // HI/LO write.
    drive(0, 0, 0, 1, 0, 5'd0, 3'b000, 2'd0, 32'h0, 32'h0, 1, 32'hA, 32'hB, 32'h134, 32'h0);
    // Bubble instruction (mem_valid=0) does not retire or write.
    drive(0, 0, 0, 0, 1, 5'd14, 3'b000, 2'd0, 32'h14141414, 32'h0, 1, 32'hC, 32'hD, 32'h138, 32'h14141414);

    // Counter wrap: preload to all-ones between edges, then retire one.
    @(negedge clk);
    force dut.retire_cnt = 32'hFFFFFFFF;
    #1;
    release dut.retire_cnt;
    #1;
    model.cnt = 32'hFFFFFFFF;
    check("preload.cnt", retire_cnt, 32'hFFFFFFFF);
    cap(5'd15, 3'b000, 2'd0, 32'h15151515, 32'h0, 32'h13C, 32'h15151515);

    // Asynchronous reset mid-cycle while wb_we is high.
    cap(5'd16, 3'b000, 2'd0, 32'h16161616, 32'h0, 32'h140, 32'h16161616);
    @(posedge clk);
    #3;
    check("pre_reset.we", 32'(wb_we), 32'd1);
    rst = 1'b0;
    #1;
    check_all("async_reset", '{default: '0});
    model = '{default: '0};
    flush = 0; stall_mem = 0; stall_wb = 0; mem_valid = 0; mem_we = 0; mem_hilo_we = 0;
    @(negedge clk);
    rst = 1'b1;
    // First edge after reset performs a normal capture.
    cap(5'd17, 3'b000, 2'd0, 32'h17171717, 32'h0, 32'h144, 32'h17171717);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
